// File: rtl/sysp_icb_arb.sv
// Two-master to one-slave ICB arbiter, one outstanding transaction, round-robin grant.
// Optional read-response timeout enabled by defining SYSP_ARB_TIMEOUT_EN.
module sysp_icb_arb #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_icb_cmd_valid,
    output logic        m0_icb_cmd_ready,
    input  logic [31:0] m0_icb_cmd_addr,
    input  logic        m0_icb_cmd_read,
    input  logic [31:0] m0_icb_cmd_wdata,
    input  logic [3:0]  m0_icb_cmd_wmask,
    output logic        m0_icb_rsp_valid,
    input  logic        m0_icb_rsp_ready,
    output logic        m0_icb_rsp_err,
    output logic [31:0] m0_icb_rsp_rdata,

    input  logic        m1_icb_cmd_valid,
    output logic        m1_icb_cmd_ready,
    input  logic [31:0] m1_icb_cmd_addr,
    input  logic        m1_icb_cmd_read,
    input  logic [31:0] m1_icb_cmd_wdata,
    input  logic [3:0]  m1_icb_cmd_wmask,
    output logic        m1_icb_rsp_valid,
    input  logic        m1_icb_rsp_ready,
    output logic        m1_icb_rsp_err,
    output logic [31:0] m1_icb_rsp_rdata,

    output logic        s_icb_cmd_valid,
    input  logic        s_icb_cmd_ready,
    output logic [31:0] s_icb_cmd_addr,
    output logic        s_icb_cmd_read,
    output logic [31:0] s_icb_cmd_wdata,
    output logic [3:0]  s_icb_cmd_wmask,
    input  logic        s_icb_rsp_valid,
    output logic        s_icb_rsp_ready,
    input  logic        s_icb_rsp_err,
    input  logic [31:0] s_icb_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        WRSP   = 2'd2
    } state_t;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_range
        $error("TIMEOUT_CYC must be in 1..255");
    end

    state_t      state, state_nxt;
    logic        last_grant;
    logic        owner;
    logic        gnt;
    logic        any_valid;
    logic        cmd_hs;
    logic        owner_rsp_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        rsp_done;
    logic        err_rsp;

`ifdef SYSP_ARB_TIMEOUT_EN
    logic [7:0]  to_cnt;
    logic        to_hit;

    // Once the timeout fires the error response is held until accepted, even if the slave answers late.
    always_comb begin
        err_rsp = (state == WAIT_R) &&
                  (to_hit || (!s_icb_rsp_valid && (to_cnt == 8'(TIMEOUT_CYC - 1))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
            to_hit <= 1'b0;
        end else if (state != WAIT_R) begin
            to_cnt <= '0;
            to_hit <= 1'b0;
        end else begin
            to_hit <= err_rsp;
            if (!err_rsp && !s_icb_rsp_valid) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end
`else
    always_comb begin
        err_rsp = 1'b0;
    end
`endif

    always_comb begin
        any_valid = m0_icb_cmd_valid | m1_icb_cmd_valid;
        gnt       = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? ~last_grant : m1_icb_cmd_valid;

        s_icb_cmd_valid = (state == IDLE) & any_valid;
        s_icb_cmd_addr  = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
        s_icb_cmd_read  = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
        s_icb_cmd_wdata = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
        s_icb_cmd_wmask = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

        m0_icb_cmd_ready = s_icb_cmd_valid & ~gnt & s_icb_cmd_ready;
        m1_icb_cmd_ready = s_icb_cmd_valid &  gnt & s_icb_cmd_ready;
        cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;
    end

    always_comb begin
        owner_rsp_ready = owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
        rsp_valid       = 1'b0;
        rsp_err         = 1'b0;
        rsp_rdata       = '0;
        rsp_done        = 1'b0;
        s_icb_rsp_ready = 1'b1;
        state_nxt       = state;

        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    state_nxt = s_icb_cmd_read ? WAIT_R : WRSP;
                end
            end
            WAIT_R: begin
                if (err_rsp) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    rsp_done  = owner_rsp_ready;
                end else begin
                    rsp_valid       = s_icb_rsp_valid;
                    rsp_err         = s_icb_rsp_err;
                    rsp_rdata       = s_icb_rsp_rdata;
                    s_icb_rsp_ready = owner_rsp_ready;
                    rsp_done        = s_icb_rsp_valid & owner_rsp_ready;
                end
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            WRSP: begin
                // The slave never answers writes, so the arbiter completes them itself.
                rsp_valid = 1'b1;
                rsp_done  = owner_rsp_ready;
                if (rsp_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        m0_icb_rsp_valid = rsp_valid & ~owner;
        m0_icb_rsp_err   = rsp_err   & ~owner;
        m0_icb_rsp_rdata = owner ? '0 : rsp_rdata;
        m1_icb_rsp_valid = rsp_valid &  owner;
        m1_icb_rsp_err   = rsp_err   &  owner;
        m1_icb_rsp_rdata = owner ? rsp_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_hs) begin
                owner      <= gnt;
                last_grant <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_sysp_icb_arb.sv
// Directed self-checking bench for sysp_icb_arb: a grant table plus multi-cycle sequences.
// Timeout sequence is compiled in only with SYSP_ARB_TIMEOUT_EN defined.
module tb_sysp_icb_arb;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
    logic [31:0] m0_icb_cmd_addr, m0_icb_cmd_wdata;
    logic [3:0]  m0_icb_cmd_wmask;
    logic        m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
    logic [31:0] m0_icb_rsp_rdata;
    logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
    logic [31:0] m1_icb_cmd_addr, m1_icb_cmd_wdata;
    logic [3:0]  m1_icb_cmd_wmask;
    logic        m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
    logic [31:0] m1_icb_rsp_rdata;
    logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
    logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
    logic [3:0]  s_icb_cmd_wmask;
    logic        s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
    logic [31:0] s_icb_rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    sysp_icb_arb #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
        .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
        .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
        .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
        .m0_icb_rsp_err(m0_icb_rsp_err), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
        .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
        .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
        .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
        .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
        .m1_icb_rsp_err(m1_icb_rsp_err), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
        .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
        .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
        .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
        .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
        .s_icb_rsp_err(s_icb_rsp_err), .s_icb_rsp_rdata(s_icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m0v;
        logic        m1v;
        logic        scr;
        logic        ev;
        logic        er0;
        logic        er1;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        m0_icb_cmd_valid = 1'b0; m0_icb_cmd_addr = A0; m0_icb_cmd_read = 1'b1;
        m0_icb_cmd_wdata = 32'h0; m0_icb_cmd_wmask = 4'h0; m0_icb_rsp_ready = 1'b1;
        m1_icb_cmd_valid = 1'b0; m1_icb_cmd_addr = A1; m1_icb_cmd_read = 1'b1;
        m1_icb_cmd_wdata = 32'h0; m1_icb_cmd_wmask = 4'h0; m1_icb_rsp_ready = 1'b1;
        s_icb_cmd_ready  = 1'b0; s_icb_rsp_valid = 1'b0; s_icb_rsp_err = 1'b0;
        s_icb_rsp_rdata  = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            m0v   m1v   scr   ev    er0   er1   eaddr
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, A0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, A1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, A0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, A1};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_cmd_valid", 32'(s_icb_cmd_valid), 32'd0);
        chk("rst_m0_rsp_valid", 32'(m0_icb_rsp_valid), 32'd0);
        chk("rst_m1_rsp_valid", 32'(m1_icb_rsp_valid), 32'd0);
        chk("rst_s_rsp_ready", 32'(s_icb_rsp_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational grant table; valids drop before each posedge so no handshake occurs.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            m0_icb_cmd_valid = tbl[i].m0v;
            m1_icb_cmd_valid = tbl[i].m1v;
            s_icb_cmd_ready  = tbl[i].scr;
            #1;
            chk($sformatf("tbl%0d_s_valid", i), 32'(s_icb_cmd_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_m0_ready", i), 32'(m0_icb_cmd_ready), 32'(tbl[i].er0));
            chk($sformatf("tbl%0d_m1_ready", i), 32'(m1_icb_cmd_ready), 32'(tbl[i].er1));
            if (tbl[i].ev) chk($sformatf("tbl%0d_addr", i), s_icb_cmd_addr, tbl[i].eaddr);
            m0_icb_cmd_valid = 1'b0;
            m1_icb_cmd_valid = 1'b0;
            s_icb_cmd_ready  = 1'b0;
        end

        // Simultaneous reads after reset: m0 then m1, no overlap on the slave.
        @(negedge clk);
        m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1; s_icb_cmd_ready = 1'b1;
        #1;
        chk("rd2_m0_gnt", 32'(m0_icb_cmd_ready), 32'd1);
        chk("rd2_m1_wait", 32'(m1_icb_cmd_ready), 32'd0);
        chk("rd2_addr0", s_icb_cmd_addr, A0);
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hCAFE_0000;
        #1;
        chk("rd2_no_overlap", 32'(s_icb_cmd_valid), 32'd0);
        chk("rd2_m1_blocked", 32'(m1_icb_cmd_ready), 32'd0);
        chk("rd2_m0_rsp_valid", 32'(m0_icb_rsp_valid), 32'd1);
        chk("rd2_m0_rdata", m0_icb_rsp_rdata, 32'hCAFE_0000);
        chk("rd2_m1_rsp_quiet", 32'(m1_icb_rsp_valid), 32'd0);
        chk("rd2_s_rsp_ready", 32'(s_icb_rsp_ready), 32'd1);
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        #1;
        chk("rd2_m1_gnt", 32'(m1_icb_cmd_ready), 32'd1);
        chk("rd2_addr1", s_icb_cmd_addr, A1);
        chk("rd2_m0_rsp_done", 32'(m0_icb_rsp_valid), 32'd0);
        @(negedge clk);
        m1_icb_cmd_valid = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hBEEF_0001;
        #1;
        chk("rd2_m1_rsp_valid", 32'(m1_icb_rsp_valid), 32'd1);
        chk("rd2_m1_rdata", m1_icb_rsp_rdata, 32'hBEEF_0001);
        chk("rd2_m0_rsp_quiet", 32'(m0_icb_rsp_valid), 32'd0);
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        #1;
        chk("rd2_m1_rsp_done", 32'(m1_icb_rsp_valid), 32'd0);

        // m0 write, locally completed one cycle after the handshake.
        @(negedge clk);
        m0_icb_cmd_valid = 1'b1; m0_icb_cmd_read = 1'b0; m0_icb_cmd_addr = 32'h0000_0F00;
        m0_icb_cmd_wdata = 32'hA5A5_0001; m0_icb_cmd_wmask = 4'hF;
        #1;
        chk("wr_s_valid", 32'(s_icb_cmd_valid), 32'd1);
        chk("wr_s_read", 32'(s_icb_cmd_read), 32'd0);
        chk("wr_s_addr", s_icb_cmd_addr, 32'h0000_0F00);
        chk("wr_s_wdata", s_icb_cmd_wdata, 32'hA5A5_0001);
        chk("wr_s_wmask", 32'(s_icb_cmd_wmask), 32'hF);
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0;
        #1;
        chk("wr_m0_rsp_valid", 32'(m0_icb_rsp_valid), 32'd1);
        chk("wr_m0_rsp_err", 32'(m0_icb_rsp_err), 32'd0);
        chk("wr_m0_rdata", m0_icb_rsp_rdata, 32'h0);
        chk("wr_m1_rsp_quiet", 32'(m1_icb_rsp_valid), 32'd0);
        chk("wr_s_single_cmd", 32'(s_icb_cmd_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("wr_rsp_done", 32'(m0_icb_rsp_valid), 32'd0);
        m0_icb_cmd_read = 1'b1; m0_icb_cmd_addr = A0;

        // m1 read with rsp_ready held low for 5 cycles while m0 waits.
        @(negedge clk);
        m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1;
        #1;
        chk("bp_m1_gnt", 32'(m1_icb_cmd_ready), 32'd1);
        chk("bp_m0_wait", 32'(m0_icb_cmd_ready), 32'd0);
        @(negedge clk);
        m1_icb_cmd_valid = 1'b0; m1_icb_rsp_ready = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_s_rsp_ready", k), 32'(s_icb_rsp_ready), 32'd0);
            chk($sformatf("bp%0d_m0_cmd_ready", k), 32'(m0_icb_cmd_ready), 32'd0);
            chk($sformatf("bp%0d_m1_rsp_valid", k), 32'(m1_icb_rsp_valid), 32'd1);
            chk($sformatf("bp%0d_m1_rdata", k), m1_icb_rsp_rdata, 32'h1234_5678);
            @(negedge clk);
        end
        m1_icb_rsp_ready = 1'b1;
        #1;
        chk("bp_s_rsp_ready", 32'(s_icb_rsp_ready), 32'd1);
        chk("bp_m0_still_wait", 32'(m0_icb_cmd_ready), 32'd0);
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        #1;
        chk("bp_m0_gnt_after", 32'(m0_icb_cmd_ready), 32'd1);
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0;
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'h0000_00AA;
        #1;
        chk("bp_m0_rdata", m0_icb_rsp_rdata, 32'h0000_00AA);

        // Reset asserted while m1 has a read outstanding.
        @(negedge clk);
        s_icb_rsp_valid = 1'b0;
        m1_icb_cmd_valid = 1'b1;
        #1;
        chk("rstw_m1_gnt", 32'(m1_icb_cmd_ready), 32'd1);
        @(negedge clk);
        m1_icb_cmd_valid = 1'b0;
        #1;
        chk("rstw_pending", 32'(m1_icb_rsp_valid), 32'd0);
        rst_n = 1'b0;
        s_icb_rsp_valid = 1'b1;
        #1;
        chk("rstw_m0_rsp_valid", 32'(m0_icb_rsp_valid), 32'd0);
        chk("rstw_m1_rsp_valid", 32'(m1_icb_rsp_valid), 32'd0);
        chk("rstw_s_cmd_valid", 32'(s_icb_cmd_valid), 32'd0);
        chk("rstw_s_rsp_ready", 32'(s_icb_rsp_ready), 32'd1);
        @(negedge clk);
        s_icb_rsp_valid = 1'b0; rst_n = 1'b1;
        m0_icb_cmd_read = 1'b0; m1_icb_cmd_read = 1'b0;
        m0_icb_cmd_valid = 1'b1; m1_icb_cmd_valid = 1'b1;
        #1;
        chk("rstw_m0_prio", 32'(m0_icb_cmd_ready), 32'd1);
        chk("rstw_m1_lose", 32'(m1_icb_cmd_ready), 32'd0);

        // Eight back-to-back writes with both masters always requesting.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("alt%0d_m0_ready", i), 32'(m0_icb_cmd_ready), 32'(i % 2 == 0));
            chk($sformatf("alt%0d_m1_ready", i), 32'(m1_icb_cmd_ready), 32'(i % 2 == 1));
            @(negedge clk);
            #1;
            chk($sformatf("alt%0d_m0_rsp", i), 32'(m0_icb_rsp_valid), 32'(i % 2 == 0));
            chk($sformatf("alt%0d_m1_rsp", i), 32'(m1_icb_rsp_valid), 32'(i % 2 == 1));
            @(negedge clk);
            #1;
        end
        m0_icb_cmd_valid = 1'b0; m1_icb_cmd_valid = 1'b0;
        m0_icb_cmd_read = 1'b1; m1_icb_cmd_read = 1'b1;

`ifdef SYSP_ARB_TIMEOUT_EN
        // Silent slave: error response 16 cycles after the handshake, late response dropped.
        @(negedge clk);
        m0_icb_cmd_valid = 1'b1; m0_icb_rsp_ready = 1'b0;
        #1;
        chk("to_m0_gnt", 32'(m0_icb_cmd_ready), 32'd1);
        @(negedge clk);
        m0_icb_cmd_valid = 1'b0;
        for (int k = 1; k < 16; k++) begin
            #1;
            chk($sformatf("to_quiet%0d", k), 32'(m0_icb_rsp_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("to_rsp_valid", 32'(m0_icb_rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(m0_icb_rsp_err), 32'd1);
        chk("to_rsp_rdata", m0_icb_rsp_rdata, 32'h0);
        @(negedge clk);
        s_icb_rsp_valid = 1'b1; s_icb_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        chk("to_hold_err", 32'(m0_icb_rsp_err), 32'd1);
        chk("to_hold_rdata", m0_icb_rsp_rdata, 32'h0);
        chk("to_drain_late", 32'(s_icb_rsp_ready), 32'd1);
        m0_icb_rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("to_done", 32'(m0_icb_rsp_valid), 32'd0);
        chk("to_stray_m1", 32'(m1_icb_rsp_valid), 32'd0);
        chk("to_stray_ready", 32'(s_icb_rsp_ready), 32'd1);
        s_icb_rsp_valid = 1'b0;
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sysp_icb_arb.md
SYSP_ICB_ARB -- requirements
Module: sysp_icb_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, giving read-response timeout in clk cycles (1..255); it is used only with SYSP_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have, for each master port mN (N=0,1), mN_icb_cmd_valid in 1, mN_icb_cmd_ready out 1, mN_icb_cmd_addr in 32, mN_icb_cmd_read in 1, mN_icb_cmd_wdata in 32, mN_icb_cmd_wmask in 4.
REQ-005 SHALL have, for each master port mN, mN_icb_rsp_valid out 1, mN_icb_rsp_ready in 1, mN_icb_rsp_err out 1, mN_icb_rsp_rdata out 32.
REQ-006 SHALL have slave port s_icb_cmd_valid out 1, s_icb_cmd_ready in 1, s_icb_cmd_addr out 32, s_icb_cmd_read out 1, s_icb_cmd_wdata out 32, s_icb_cmd_wmask out 4.
REQ-007 SHALL have slave port s_icb_rsp_valid in 1, s_icb_rsp_ready out 1, s_icb_rsp_err in 1, s_icb_rsp_rdata in 32; the slave is the system-peripheral bus.

Function
REQ-008 SHALL share one slave between two masters with one outstanding transaction at a time.
REQ-009 SHALL implement states IDLE, WAIT_R (read outstanding) and WRSP (local write response).
REQ-010 In IDLE, SHALL grant combinationally among valid masters by round-robin: the master not granted last wins when both are valid.
REQ-011 In IDLE, SHALL drive s_icb_cmd_* from the granted master; the granted master's cmd_ready = s_icb_cmd_ready.
REQ-012 The non-granted master's cmd_ready SHALL be 0, and all master cmd_ready SHALL be 0 outside IDLE.
REQ-013 s_icb_cmd_valid SHALL be 0 outside IDLE or when no master is valid.
REQ-014 On slave cmd handshake, SHALL latch owner and last_grant, then go to WAIT_R if read, else WRSP.
REQ-015 In WRSP, the slave issues no write response, so the arbiter SHALL assert owner rsp_valid with rsp_err=0 and rdata=0.
REQ-016 In WRSP, SHALL go to IDLE on owner rsp_ready; write response latency is 1 cycle after the cmd handshake.
REQ-017 In WAIT_R, SHALL route s_icb_rsp_valid, err and rdata to the owner only, with s_icb_rsp_ready = owner rsp_ready.
REQ-018 In WAIT_R, SHALL go to IDLE on the s_icb_rsp_valid & owner rsp_ready handshake.
REQ-019 Outside WAIT_R, s_icb_rsp_ready SHALL be 1 so stray slave responses are drained and dropped; the non-owner rsp_valid SHALL always be 0.
REQ-020 A new command SHALL be granted at the earliest in the cycle after the response handshake returns the FSM to IDLE.
REQ-021 A master that deasserts cmd_valid before its handshake SHALL lose the grant with no side effects.

Reset
REQ-022 On rst_n low, SHALL set state=IDLE and last_grant=1, so m0 has first priority.
REQ-023 On rst_n low, SHALL zero the timeout counter and owner register; all rsp_valid and s_icb_cmd_valid read 0 during reset.
REQ-024 Reset mid-transaction SHALL abandon the transaction and emit no response.

Configuration
REQ-025 With SYSP_ARB_TIMEOUT_EN defined, SHALL count WAIT_R cycles and, on reaching TIMEOUT_CYC without s_icb_rsp_valid, present an owner response with err=1 and rdata=32'h0.
REQ-026 With SYSP_ARB_TIMEOUT_EN defined, that error response SHALL complete on owner rsp_ready, return to IDLE, and drop any late slave response per REQ-019.
REQ-027 With SYSP_ARB_TIMEOUT_EN undefined, SHALL have no counter, and WAIT_R SHALL wait indefinitely.

Verification
REQ-028 Both masters issue reads together after reset -> m0 granted first, m1 second; each gets the slave rdata; the slave sees no overlap.
REQ-029 m0 writes addr 0x0000_0F00, data 0xA5A5_0001, wmask 4'hF -> the slave sees one cmd; m0 rsp_valid comes 1 cycle later with err=0; no slave rsp is awaited.
REQ-030 m1 holds rsp_ready=0 for 5 cycles during a read -> s_icb_rsp_ready=0 for those cycles; a pending m0 cmd stays cmd_ready=0 until the handshake.
REQ-031 Continuous requests from both masters for 8 transactions -> grants alternate m0,m1,m0,...
REQ-032 With SYSP_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the slave never responds -> owner rsp_valid at cycle 16 with err=1 and rdata=0; a late slave rsp is absorbed.
REQ-033 Assert rst_n low in WAIT_R -> all rsp_valid=0; after release the state is IDLE and m0 has priority.
